cnn_frame_sequencer: RTL and testbench
======================================

CNN_FRAME_SEQUENCER -- requirements
Module: cnn_frame_sequencer

Interface
REQ-001 Parameters SHALL be: IMG_PIXELS, default 1024, pixels per frame (32x32); PIXEL_GAP, default 0, idle cycles between successive pixels; TIMEOUT_CYCLES, default 65535, maximum wait for a CNN result.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous reset, active-low
- i_frame_req  in  1  one-cycle request to process one frame
- i_abort  in  1  synchronous abort of the current frame
- o_mem_rd_en  out  1  pixel-memory read strobe
- o_mem_addr  out  $clog2(IMG_PIXELS)  pixel-memory read address
- i_mem_rdata  in  8  read data, valid exactly 1 cycle after o_mem_rd_en
- o_start_signal  out  1  CNN frame-start pulse
- o_pixel_valid  out  1  CNN pixel strobe
- o_pixel_in  out  8  CNN pixel value
- i_cnn_busy  in  1  CNN busy status
- i_result_valid  in  1  CNN result strobe
- i_lane_result  in  48 signed  CNN result
- o_result_valid  out  1  one-cycle pulse when a new result is latched
- o_lane_result  out  48 signed  last captured result, held
- o_busy  out  1  high whenever the FSM is not in IDLE
- o_timeout  out  1  sticky timeout flag
- o_frame_count  out  16  completed-frame counter

Function
REQ-003 FSM states SHALL be IDLE, START, STREAM, WAIT_RESULT, DONE; o_busy SHALL equal (state != IDLE).
REQ-004 In IDLE, an i_frame_req pulse SHALL set a pending flag. Requests received in any other state SHALL be ignored and not queued.
REQ-005 IDLE->START SHALL occur when pending==1 and i_cnn_busy==0. Pending SHALL clear on that transition. With i_cnn_busy==1, the FSM SHALL stay in IDLE with pending held.
REQ-006 Entering START SHALL clear o_timeout.
REQ-007 START SHALL last 1 cycle: o_start_signal=1, o_mem_rd_en=1, o_mem_addr=0. Next state SHALL be STREAM.
REQ-008 Read issue rule: address k SHALL be issued PIXEL_GAP+1 cycles after address k-1, for k=1..IMG_PIXELS-1.
REQ-009 Output timing: o_pixel_valid SHALL be registered, asserting 2 cycles after each read strobe for exactly 1 cycle. o_pixel_in SHALL equal the i_mem_rdata of that read. Both SHALL hold 0 otherwise.
REQ-010 Pixel count: exactly IMG_PIXELS pixels SHALL be emitted per frame, in address order. The last pixel SHALL assert at T0+2+(IMG_PIXELS-1)*(PIXEL_GAP+1), where T0 is the START cycle.
REQ-011 STREAM->WAIT_RESULT SHALL occur in the cycle the last pixel is emitted. The timeout counter SHALL reset to 0 on entry.
REQ-012 In WAIT_RESULT, the counter SHALL increment each cycle.
REQ-013 On i_result_valid in WAIT_RESULT:
- o_lane_result <= i_lane_result;
- o_result_valid=1 on the next cycle, for 1 cycle;
- o_frame_count increments, wrapping 65535->0;
- next state SHALL be DONE.
REQ-014 DONE SHALL last 1 cycle, then go to IDLE.
REQ-015 When the counter reaches TIMEOUT_CYCLES-1 without a result: o_timeout<=1 (sticky); next state IDLE; no result pulse; o_frame_count unchanged.
REQ-016 A result and the timeout limit in the same cycle: the result SHALL win and o_timeout SHALL stay 0.
REQ-017 i_result_valid outside WAIT_RESULT SHALL be ignored; o_lane_result and o_frame_count unchanged.
REQ-018 i_abort in START, STREAM or WAIT_RESULT:
- next state IDLE;
- o_mem_rd_en, o_pixel_valid and o_start_signal SHALL be 0 from the next cycle, including any pixel still in the read pipeline;
- o_frame_count unchanged.
i_abort in IDLE SHALL clear pending.
REQ-019 Zero-gap case: with PIXEL_GAP=0, reads and pixels SHALL be back-to-back with no bubbles.

Reset
REQ-020 rst low SHALL immediately force IDLE, pending=0, counters=0 and all outputs 0, including o_lane_result, o_timeout and o_frame_count.
REQ-021 Reset asserted mid-frame SHALL drop o_pixel_valid at once. After release, no stale pixel or result SHALL be emitted.

Verification
REQ-022 Scenario: IMG_PIXELS=1024, PIXEL_GAP=0, memory[k]=k[7:0], req at cycle 10 with cnn_busy=0 -> start at 11, pixels 0..255 repeating on cycles 13..1036, WAIT_RESULT at 1036.
REQ-023 Scenario: IMG_PIXELS=4, PIXEL_GAP=2 -> pixel strobes 3 cycles apart; result 48'sh800000000001 20 cycles later -> o_result_valid pulse, o_lane_result matches, o_frame_count=1.
REQ-024 Scenario: req while cnn_busy=1 for 50 cycles -> no start until busy drops, then start exactly 1 cycle later; a second req during STREAM produces no second frame.
REQ-025 Scenario: TIMEOUT_CYCLES=16, no result -> o_timeout=1 after 16 WAIT_RESULT cycles, IDLE, count unchanged. Next req clears o_timeout at START.
REQ-026 Scenario: i_abort at pixel 2 of 4 -> no further pixels, IDLE. Stray i_result_valid afterwards -> ignored.
REQ-027 Scenario: rst low mid-STREAM for 1 cycle -> all outputs 0 at once. A fresh req after release runs a clean full frame.

Source files
------------

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: reads one frame of pixels from memory, streams it
// into a CNN, then waits (bounded by a timeout) for the CNN result.
// Ports:
//   clk, rst                       clock, async active-low reset
//   i_frame_req, i_abort           frame request / abort
//   o_mem_rd_en, o_mem_addr,
//   i_mem_rdata                    pixel memory read port (1-cycle latency)
//   o_start_signal, o_pixel_valid,
//   o_pixel_in                     CNN frame start and pixel stream
//   i_cnn_busy, i_result_valid,
//   i_lane_result                  CNN status and result
//   o_result_valid, o_lane_result  captured result and its pulse
//   o_busy, o_timeout,
//   o_frame_count                  status
module cnn_frame_sequencer #(
   parameter int IMG_PIXELS     = 1024,
   parameter int PIXEL_GAP      = 0,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_frame_req,
   input  logic                          i_abort,
   output logic                          o_mem_rd_en,
   output logic [$clog2(IMG_PIXELS)-1:0] o_mem_addr,
   input  logic [7:0]                    i_mem_rdata,
   output logic                          o_start_signal,
   output logic                          o_pixel_valid,
   output logic [7:0]                    o_pixel_in,
   input  logic                          i_cnn_busy,
   input  logic                          i_result_valid,
   input  logic signed [47:0]            i_lane_result,
   output logic                          o_result_valid,
   output logic signed [47:0]            o_lane_result,
   output logic                          o_busy,
   output logic                          o_timeout,
   output logic [15:0]                   o_frame_count
);

   localparam int AW = $clog2(IMG_PIXELS);
   localparam int CW = AW + 1;
   localparam int GW = (PIXEL_GAP > 0) ? $clog2(PIXEL_GAP + 1) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] N_PIX     = CW'(IMG_PIXELS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_PIXELS - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(PIXEL_GAP);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]         state;
   logic [2:0]         state_nx;
   logic               pending;
   logic [CW-1:0]      next_addr;
   logic [GW-1:0]      gap_cnt;
   logic               rd_q1;
   logic               q1_last;
   logic               pix_valid_q;
   logic [7:0]         pix_q;
   logic [TW-1:0]      to_cnt;
   logic               timeout_q;
   logic               res_valid_q;
   logic signed [47:0] lane_q;
   logic [15:0]        frame_cnt;

   logic in_run;
   logic abort_run;
   logic gap_hit;
   logic issue_stream;
   logic last_pix;
   logic res_take;
   logic to_take;

   assign in_run = (state == S_START) |
                   (state == S_STREAM) |
                   (state == S_WAIT);
   assign abort_run = i_abort & in_run;

   assign gap_hit = (gap_cnt == GAP_LAST);
   assign issue_stream = (state == S_STREAM) & gap_hit &
                         (next_addr < N_PIX);

   // Address 0 goes out in START, the rest are paced by the gap counter.
   assign o_mem_rd_en = (state == S_START) | issue_stream;
   assign o_mem_addr  = issue_stream ? next_addr[AW-1:0] : '0;

   // The final read's data is being registered this edge, so the last
   // pixel becomes visible in the first WAIT_RESULT cycle.
   assign last_pix = rd_q1 & q1_last;

   // A result arriving on the timeout's last cycle still counts.
   assign res_take = (state == S_WAIT) & i_result_valid & ~i_abort;
   assign to_take  = (state == S_WAIT) & ~i_result_valid & ~i_abort &
                     (to_cnt == TO_LAST);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:
            if (!i_abort && (pending || i_frame_req) && !i_cnn_busy)
               state_nx = S_START;
         S_START:
            state_nx = i_abort ? S_IDLE : S_STREAM;
         S_STREAM:
            if (i_abort)       state_nx = S_IDLE;
            else if (last_pix) state_nx = S_WAIT;
         S_WAIT:
            if (i_abort)       state_nx = S_IDLE;
            else if (res_take) state_nx = S_DONE;
            else if (to_take)  state_nx = S_IDLE;
         S_DONE:
            state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         pending     <= 1'b0;
         next_addr   <= '0;
         gap_cnt     <= '0;
         rd_q1       <= 1'b0;
         q1_last     <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_q       <= '0;
         to_cnt      <= '0;
         timeout_q   <= 1'b0;
         res_valid_q <= 1'b0;
         lane_q      <= '0;
         frame_cnt   <= '0;
      end else begin
         state       <= state_nx;
         res_valid_q <= 1'b0;

         // Requests only register while idle; they wait out a busy CNN.
         if (state == S_IDLE) begin
            if (i_abort || state_nx == S_START)
               pending <= 1'b0;
            else if (i_frame_req)
               pending <= 1'b1;
         end

         if (state_nx == S_START) begin
            next_addr <= CW'(1);
            gap_cnt   <= '0;
         end else if (issue_stream) begin
            next_addr <= next_addr + 1'b1;
            gap_cnt   <= '0;
         end else if (state == S_STREAM && !gap_hit) begin
            gap_cnt <= gap_cnt + 1'b1;
         end

         // Abort kills reads still in flight so nothing leaks out.
         rd_q1       <= o_mem_rd_en & ~abort_run;
         q1_last     <= (o_mem_addr == LAST_ADDR);
         pix_valid_q <= rd_q1 & ~abort_run;
         pix_q       <= (rd_q1 & ~abort_run) ? i_mem_rdata : 8'd0;

         if (state == S_WAIT)
            to_cnt <= to_cnt + 1'b1;
         else
            to_cnt <= '0;

         if (state_nx == S_START)
            timeout_q <= 1'b0;
         else if (to_take)
            timeout_q <= 1'b1;

         if (res_take) begin
            lane_q      <= i_lane_result;
            res_valid_q <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
         end
      end
   end

   assign o_start_signal = (state == S_START);
   assign o_pixel_valid  = pix_valid_q;
   assign o_pixel_in     = pix_q;
   assign o_result_valid = res_valid_q;
   assign o_lane_result  = lane_q;
   assign o_busy         = (state != S_IDLE);
   assign o_timeout      = timeout_q;
   assign o_frame_count  = frame_cnt;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: cycle vector table on a 4-pixel, gap-2 instance
// plus hand sequences for reset mid-frame and a 1024-pixel zero-gap frame.
module tb_cnn_frame_sequencer;

   localparam int NV = 117;
   localparam logic [47:0] R1 = 48'h800000000001;
   localparam logic [47:0] R2 = 48'hFFFFFFFFFFFB;
   localparam logic [47:0] R3 = 48'h000012345678;
   localparam logic [47:0] R4 = 48'h7FFF00000042;

   typedef struct packed {
      logic        req;
      logic        abort;
      logic        busy;
      logic        rv;
      logic [47:0] lr;
      logic        e_st;
      logic        e_rd;
      logic [1:0]  e_addr;
      logic        e_pv;
      logic [7:0]  e_pix;
      logic        e_busy;
      logic        e_rv;
      logic        e_to;
      logic [15:0] e_fc;
      logic [47:0] e_lane;
   } vec_t;

   vec_t tv [NV];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               req_a;
   logic               req_b;
   logic               abort;
   logic               cbusy;
   logic               rv;
   logic signed [47:0] lr;

   logic               rd_a;
   logic [1:0]         addr_a;
   logic [7:0]         rdata_a;
   logic               st_a;
   logic               pv_a;
   logic [7:0]         pix_a;
   logic               orv_a;
   logic signed [47:0] lane_a;
   logic               busy_a;
   logic               to_a;
   logic [15:0]        fc_a;

   logic               rd_b;
   logic [9:0]         addr_b;
   logic [7:0]         rdata_b;
   logic               st_b;
   logic               pv_b;
   logic [7:0]         pix_b;
   logic               orv_b;
   logic signed [47:0] lane_b;
   logic               busy_b;
   logic               to_b;
   logic [15:0]        fc_b;

   int errs   = 0;
   int checks = 0;

   cnn_frame_sequencer #(
      .IMG_PIXELS     (4),
      .PIXEL_GAP      (2),
      .TIMEOUT_CYCLES (16)
   ) u_a (
      .clk            (clk),
      .rst            (rst),
      .i_frame_req    (req_a),
      .i_abort        (abort),
      .o_mem_rd_en    (rd_a),
      .o_mem_addr     (addr_a),
      .i_mem_rdata    (rdata_a),
      .o_start_signal (st_a),
      .o_pixel_valid  (pv_a),
      .o_pixel_in     (pix_a),
      .i_cnn_busy     (cbusy),
      .i_result_valid (rv),
      .i_lane_result  (lr),
      .o_result_valid (orv_a),
      .o_lane_result  (lane_a),
      .o_busy         (busy_a),
      .o_timeout      (to_a),
      .o_frame_count  (fc_a)
   );

   cnn_frame_sequencer #(
      .IMG_PIXELS     (1024),
      .PIXEL_GAP      (0),
      .TIMEOUT_CYCLES (65535)
   ) u_b (
      .clk            (clk),
      .rst            (rst),
      .i_frame_req    (req_b),
      .i_abort        (abort),
      .o_mem_rd_en    (rd_b),
      .o_mem_addr     (addr_b),
      .i_mem_rdata    (rdata_b),
      .o_start_signal (st_b),
      .o_pixel_valid  (pv_b),
      .o_pixel_in     (pix_b),
      .i_cnn_busy     (cbusy),
      .i_result_valid (rv),
      .i_lane_result  (lr),
      .o_result_valid (orv_b),
      .o_lane_result  (lane_b),
      .o_busy         (busy_b),
      .o_timeout      (to_b),
      .o_frame_count  (fc_b)
   );

   // Pixel memories: 1-cycle read latency, filler value when not read.
   always_ff @(posedge clk)
      rdata_a <= rd_a ? (8'hA0 + {6'd0, addr_a}) : 8'h5A;
   always_ff @(posedge clk)
      rdata_b <= rd_b ? addr_b[7:0] : 8'h5A;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Expected stream of a 4-pixel gap-2 frame starting at t0,
   // cut off at te (first idle cycle).
   task automatic frame(input int t0, input int te);
      for (int t = t0; t < te; t++)
         tv[t].e_busy = 1'b1;
      tv[t0].e_st = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (t0 + 3 * k < te) begin
            tv[t0 + 3 * k].e_rd   = 1'b1;
            tv[t0 + 3 * k].e_addr = 2'(k);
         end
         if (t0 + 2 + 3 * k < te) begin
            tv[t0 + 2 + 3 * k].e_pv  = 1'b1;
            tv[t0 + 2 + 3 * k].e_pix = 8'hA0 + 8'(k);
         end
      end
   endtask

   initial begin
      int good;
      logic       e_st;
      logic       e_rd;
      logic [9:0] e_addr;
      logic       e_pv;
      logic [7:0] e_pix;
      logic       e_p;

      for (int i = 0; i < NV; i++)
         tv[i] = '0;
      tv[0].req   = 1'b1;
      tv[15].rv   = 1'b1;
      tv[15].lr   = R1;
      tv[17].rv   = 1'b1;
      tv[17].lr   = 48'd123;
      tv[18].req  = 1'b1;
      tv[47].req  = 1'b1;
      tv[74].rv   = 1'b1;
      tv[74].lr   = R2;
      tv[77].req  = 1'b1;
      for (int i = 77; i <= 81; i++)
         tv[i].busy = 1'b1;
      tv[85].req   = 1'b1;
      tv[95].abort = 1'b1;
      tv[100].req  = 1'b1;
      tv[108].abort = 1'b1;
      tv[110].rv   = 1'b1;
      tv[110].lr   = 48'd77;
      tv[112].req  = 1'b1;
      tv[112].busy = 1'b1;
      tv[113].busy = 1'b1;
      tv[113].abort = 1'b1;

      frame(1, 17);
      frame(19, 46);
      frame(48, 76);
      frame(83, 96);
      frame(101, 109);
      for (int i = 0; i < NV; i++) begin
         tv[i].e_fc   = (i >= 75) ? 16'd2 : (i >= 16) ? 16'd1 : 16'd0;
         tv[i].e_lane = (i >= 75) ? R2 : (i >= 16) ? R1 : 48'd0;
         tv[i].e_to   = (i == 46 || i == 47);
         tv[i].e_rv   = (i == 16 || i == 75);
      end

      rst   = 1'b1;
      req_a = 1'b0;
      req_b = 1'b0;
      abort = 1'b0;
      cbusy = 1'b0;
      rv    = 1'b0;
      lr    = '0;
      #1 rst = 1'b0;
      #1;
      chk("rst_busy_a", busy_a, 0);
      chk("rst_pv_a", pv_a, 0);
      chk("rst_to_a", to_a, 0);
      chk("rst_fc_a", fc_a, 0);
      chk("rst_lane_a", {16'h0, lane_a}, 0);
      chk("rst_busy_b", busy_b, 0);
      chk("rst_rd_b", rd_b, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1;
         req_a = tv[i].req;
         abort = tv[i].abort;
         cbusy = tv[i].busy;
         rv    = tv[i].rv;
         lr    = tv[i].lr;
         @(negedge clk);
         chk($sformatf("v%0d_start", i), st_a, tv[i].e_st);
         chk($sformatf("v%0d_rd", i), rd_a, tv[i].e_rd);
         chk($sformatf("v%0d_addr", i), addr_a, tv[i].e_addr);
         chk($sformatf("v%0d_pv", i), pv_a, tv[i].e_pv);
         chk($sformatf("v%0d_pix", i), pix_a, tv[i].e_pix);
         chk($sformatf("v%0d_busy", i), busy_a, tv[i].e_busy);
         chk($sformatf("v%0d_rv", i), orv_a, tv[i].e_rv);
         chk($sformatf("v%0d_to", i), to_a, tv[i].e_to);
         chk($sformatf("v%0d_fc", i), fc_a, tv[i].e_fc);
         chk($sformatf("v%0d_lane", i), {16'h0, lane_a},
             {16'h0, tv[i].e_lane});
      end

      // Reset while streaming, then a clean frame.
      @(posedge clk);
      #1;
      req_a = 1'b1;
      abort = 1'b0;
      cbusy = 1'b0;
      rv    = 1'b0;
      lr    = '0;
      @(posedge clk);
      #1 req_a = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rs_pv_before", pv_a, 1);
      rst = 1'b0;
      #1;
      chk("rs_pv", pv_a, 0);
      chk("rs_pix", pix_a, 0);
      chk("rs_busy", busy_a, 0);
      chk("rs_rd", rd_a, 0);
      chk("rs_start", st_a, 0);
      chk("rs_fc", fc_a, 0);
      chk("rs_lane", {16'h0, lane_a}, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk($sformatf("rs_idle%0d_pv", n), pv_a, 0);
         chk($sformatf("rs_idle%0d_busy", n), busy_a, 0);
         chk($sformatf("rs_idle%0d_rv", n), orv_a, 0);
      end
      for (int n = 0; n <= 16; n++) begin
         @(posedge clk);
         #1;
         req_a = (n == 0);
         rv    = (n == 14);
         lr    = (n == 14) ? R3 : 48'd0;
         @(negedge clk);
         e_p = (n >= 3) && ((n - 3) % 3 == 0) && ((n - 3) / 3 < 4);
         chk($sformatf("rf%0d_start", n), st_a, (n == 1));
         chk($sformatf("rf%0d_pv", n), pv_a, e_p);
         chk($sformatf("rf%0d_pix", n), pix_a,
             e_p ? 8'hA0 + 8'((n - 3) / 3) : 8'h00);
         chk($sformatf("rf%0d_rv", n), orv_a, (n == 15));
         chk($sformatf("rf%0d_fc", n), fc_a, (n >= 15) ? 1 : 0);
      end
      chk("rf_lane", {16'h0, lane_a}, {16'h0, R3});
      chk("rf_busy_end", busy_a, 0);

      // Full 1024-pixel zero-gap frame.
      good = 0;
      for (int n = 0; n <= 1030; n++) begin
         @(posedge clk);
         #1;
         req_b = (n == 0);
         rv    = (n == 1028);
         lr    = (n == 1028) ? R4 : 48'd0;
         @(negedge clk);
         e_st   = (n == 1);
         e_rd   = (n >= 1) && (n <= 1024);
         e_addr = e_rd ? 10'(n - 1) : 10'd0;
         e_pv   = (n >= 3) && (n <= 1026);
         e_pix  = e_pv ? 8'(n - 3) : 8'd0;
         if (st_b === e_st && rd_b === e_rd && addr_b === e_addr &&
             pv_b === e_pv && pix_b === e_pix)
            good++;
         if (n == 1)
            chk("b_start", st_b, 1);
         if (n == 1026) begin
            chk("b_last_pv", pv_b, 1);
            chk("b_last_pix", pix_b, 8'hFF);
         end
         if (n == 1027) begin
            chk("b_after_pv", pv_b, 0);
            chk("b_wait_busy", busy_b, 1);
         end
         if (n == 1029) begin
            chk("b_rv", orv_b, 1);
            chk("b_fc", fc_b, 1);
            chk("b_lane", {16'h0, lane_b}, {16'h0, R4});
         end
         if (n == 1030) begin
            chk("b_idle", busy_b, 0);
            chk("b_rv_end", orv_b, 0);
            chk("b_to", to_b, 0);
         end
      end
      chk("b_frame_cycles", good, 1031);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
